free_list_ctrl: RTL
===================

FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 SHALL have parameter ARCH_COUNT, default 32: architectural registers; tags 0..ARCH_COUNT-1 are never initially free.
REQ-002 SHALL have parameter VIRT_COUNT, default 64: physical tags; power of two; greater than ARCH_COUNT.
REQ-003 SHALL have parameter VIRT_ADDR_WIDTH, default $clog2(VIRT_COUNT): tag width.
REQ-004 SHALL have parameter ALLOC_PORTS, default 2: rename allocation ports.
REQ-005 SHALL have parameter FREE_PORTS, default 2: commit-time release ports.
REQ-006 SHALL have port clk  in  1: sole clock, rising edge.
REQ-007 SHALL have port async_rst  in  1: reset, asynchronous, active-high.
REQ-008 SHALL have port clk_en  in  1: state advances only when high.
REQ-009 SHALL have port alloc_req  in  ALLOC_PORTS: per-port request for one new tag.
REQ-010 SHALL have port alloc_gnt  out  1: all current requests granted this cycle.
REQ-011 SHALL have port alloc_tag  out  ALLOC_PORTS x VIRT_ADDR_WIDTH: tag per port; valid only for requesting ports when alloc_gnt=1.
REQ-012 SHALL have port free_valid  in  FREE_PORTS: per-port release strobe.
REQ-013 SHALL have port free_tag  in  FREE_PORTS x VIRT_ADDR_WIDTH: tag being released.
REQ-014 SHALL have port commit_cnt  in  $clog2(ALLOC_PORTS+1): allocations retired this cycle.
REQ-015 SHALL have port flush  in  1: discard all uncommitted allocations.
REQ-016 SHALL have port init_done  out  1: free list is initialised and serving.
REQ-017 SHALL have port free_count  out  VIRT_ADDR_WIDTH+1: tags available to allocate.
REQ-018 SHALL have port overflow_err  out  1: sticky; a release found the list full.

Function
REQ-019 SHALL store tags in a circular buffer of VIRT_COUNT entries, with write pointer tail, speculative read pointer spec_head and committed read pointer commit_head, each VIRT_ADDR_WIDTH+1 bits wrapping modulo 2*VIRT_COUNT.
REQ-020 SHALL have a two-state FSM: INIT and READY.
REQ-021 In INIT, SHALL write tag ARCH_COUNT+i to entry i, one entry per enabled cycle.
REQ-022 SHALL move from INIT to READY after VIRT_COUNT-ARCH_COUNT writes, with tail=VIRT_COUNT-ARCH_COUNT and spec_head=commit_head=0.
REQ-023 SHALL make free_count=tail-spec_head combinationally; it is 0 in INIT.
REQ-024 SHALL set n to the popcount of alloc_req.
REQ-025 SHALL make alloc_gnt=1 iff READY, clk_en=1, flush=0, n>0 and free_count>=n.
REQ-026 SHALL grant all-or-nothing; there is no partial grant.
REQ-027 SHALL give the k-th requesting port, counting from port 0, the entry at spec_head+k, combinationally in the same cycle.
REQ-028 On a granted edge, spec_head SHALL advance by n.
REQ-029 On each enabled READY edge, SHALL write each free_valid tag at tail in port order and advance tail by the valid count.
REQ-030 If a write would make tail-commit_head exceed VIRT_COUNT-ARCH_COUNT, SHALL drop that tag and set overflow_err.
REQ-031 commit_head SHALL advance by commit_cnt each enabled READY edge.
REQ-032 SHALL clamp commit_head so it never passes spec_head.
REQ-033 On flush, SHALL set spec_head to commit_head after this cycle's commit_cnt update; frees in the same cycle still apply.
REQ-034 When clk_en=0, SHALL hold all state, and alloc_gnt SHALL be 0.
REQ-035 In INIT, SHALL ignore alloc_req, free_valid, commit_cnt and flush.

Reset
REQ-036 On async_rst, SHALL immediately enter INIT with all pointers 0.
REQ-037 On async_rst, SHALL set init_done=0, alloc_gnt=0, free_count=0 and overflow_err=0.
REQ-038 Asserting async_rst mid-INIT or mid-operation SHALL restart initialisation from entry 0.
REQ-039 overflow_err SHALL clear only on reset.

Verification
REQ-040 Reset release, clk_en=1 -> init_done rises after 32 cycles, with free_count=32.
REQ-041 alloc_req=2'b11 twice -> tags (32,33), then (34,35); free_count 32->30->28.
REQ-042 alloc_req=2'b10 only -> port 1 gets tag 32, alloc_gnt=1; 16 dual allocs from full -> free_count=0, then next request alloc_gnt=0 and pointers unchanged.
REQ-043 Alloc 32,33,34,35; commit_cnt=2; flush -> free_count=30; next dual alloc returns 34,35.
REQ-044 At free_count=32 with no outstanding allocations, free_valid=2'b01 -> overflow_err=1 and free_count stays 32.
REQ-045 async_rst pulse mid-INIT, and clk_en=0 during alloc_req -> INIT restarts from entry 0, and there is no grant or state change while disabled.

Source files
------------

// File: rtl/free_list_ctrl.sv
// free_list_ctrl
// Physical-register free list for a renaming pipeline. Free tags sit in a
// circular buffer between commit_head and tail. Rename allocates speculatively
// from spec_head. Commit retires allocations by advancing commit_head. A flush
// rewinds spec_head to commit_head. After reset the buffer fills itself with
// the non-architectural tags, one per enabled cycle.
//
// Ports
//   clk          : clock, rising edge
//   async_rst    : asynchronous active-high reset
//   clk_en       : state advances only while high
//   alloc_req    : per-port allocation request
//   alloc_gnt    : all requesting ports are served this cycle
//   alloc_tag    : allocated tag per port (k-th requester gets spec_head+k)
//   free_valid   : per-port release strobe
//   free_tag     : tag released on each port
//   commit_cnt   : number of allocations retired this cycle
//   flush        : discard all uncommitted allocations
//   init_done    : buffer initialised and serving
//   free_count   : tags currently available to allocate
//   overflow_err : sticky, a release found the list full
module free_list_ctrl #(
    parameter int ARCH_COUNT      = 32,
    parameter int VIRT_COUNT      = 64,
    parameter int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
    parameter int ALLOC_PORTS     = 2,
    parameter int FREE_PORTS      = 2
) (
    input  logic                                          clk,
    input  logic                                          async_rst,
    input  logic                                          clk_en,
    input  logic [ALLOC_PORTS-1:0]                        alloc_req,
    output logic                                          alloc_gnt,
    output logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]   alloc_tag,
    input  logic [FREE_PORTS-1:0]                         free_valid,
    input  logic [FREE_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]    free_tag,
    input  logic [$clog2(ALLOC_PORTS+1)-1:0]              commit_cnt,
    input  logic                                          flush,
    output logic                                          init_done,
    output logic [VIRT_ADDR_WIDTH:0]                      free_count,
    output logic                                          overflow_err
);
    localparam int AW = VIRT_ADDR_WIDTH;
    localparam int PW = VIRT_ADDR_WIDTH + 1;
    // Number of tags that are not architecturally mapped; also the buffer fill limit.
    localparam logic [PW-1:0] LIVE = PW'(VIRT_COUNT - ARCH_COUNT);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t        r_state;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_spec_head;
    logic [PW-1:0] r_commit_head;
    logic          r_init_done;
    logic          r_ovf;
    logic [AW-1:0] r_mem [VIRT_COUNT];

    logic          w_ready;
    logic [PW-1:0] w_free_count;
    logic [PW-1:0] w_n;
    logic [PW-1:0] w_k;
    logic [PW-1:0] w_rd_ptr;
    logic          w_gnt;
    logic [PW-1:0] w_tail_nxt;
    logic          w_ovf_set;
    logic [FREE_PORTS-1:0]          w_wr_en;
    logic [FREE_PORTS-1:0][AW-1:0]  w_wr_addr;
    logic [PW-1:0] w_spec_adv;
    logic [PW-1:0] w_room;
    logic [PW-1:0] w_commit_nxt;
    logic [PW-1:0] w_spec_nxt;
    logic [AW-1:0] w_init_tag;

    assign w_ready      = (r_state == ST_READY);
    assign w_free_count = w_ready ? (r_tail - r_spec_head) : '0;
    assign w_init_tag   = AW'(ARCH_COUNT) + r_tail[AW-1:0];

    always_comb begin
        w_n = '0;
        for (int p = 0; p < ALLOC_PORTS; p++) begin
            w_n = w_n + PW'(alloc_req[p]);
        end
    end

    assign w_gnt = w_ready & clk_en & ~flush & (w_n != '0) & (w_free_count >= w_n);

    // Each requester's offset from spec_head is the number of requesters below it.
    always_comb begin
        w_k      = '0;
        w_rd_ptr = r_spec_head;
        for (int p = 0; p < ALLOC_PORTS; p++) begin
            w_rd_ptr     = r_spec_head + w_k;
            alloc_tag[p] = r_mem[w_rd_ptr[AW-1:0]];
            w_k          = w_k + PW'(alloc_req[p]);
        end
    end

    // Releases append in port order. Occupancy is measured against the
    // committed head, because uncommitted allocations may still be flushed back.
    always_comb begin
        w_tail_nxt = r_tail;
        w_ovf_set  = 1'b0;
        w_wr_en    = '0;
        w_wr_addr  = '0;
        for (int p = 0; p < FREE_PORTS; p++) begin
            if (free_valid[p]) begin
                if ((w_tail_nxt - r_commit_head) < LIVE) begin
                    w_wr_en[p]   = 1'b1;
                    w_wr_addr[p] = w_tail_nxt[AW-1:0];
                    w_tail_nxt   = w_tail_nxt + PW'(1);
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
        end
    end

    // Commit may not run past the (post-allocation) speculative head.
    // A flush then rewinds speculation onto the freshly committed head.
    always_comb begin
        w_spec_adv   = w_gnt ? (r_spec_head + w_n) : r_spec_head;
        w_room       = w_spec_adv - r_commit_head;
        w_commit_nxt = (PW'(commit_cnt) > w_room) ? w_spec_adv
                                                  : (r_commit_head + PW'(commit_cnt));
        w_spec_nxt   = flush ? w_commit_nxt : w_spec_adv;
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_state       <= ST_INIT;
            r_tail        <= '0;
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_init_done   <= 1'b0;
            r_ovf         <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                ST_INIT: begin
                    r_tail <= r_tail + PW'(1);
                    if (r_tail == LIVE - PW'(1)) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_tail        <= w_tail_nxt;
                    r_spec_head   <= w_spec_nxt;
                    r_commit_head <= w_commit_nxt;
                    if (w_ovf_set) begin
                        r_ovf <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Tag storage carries no reset; contents are rebuilt by the INIT sweep.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (r_state == ST_INIT) begin
                r_mem[r_tail[AW-1:0]] <= w_init_tag;
            end else begin
                for (int p = 0; p < FREE_PORTS; p++) begin
                    if (w_wr_en[p]) begin
                        r_mem[w_wr_addr[p]] <= free_tag[p];
                    end
                end
            end
        end
    end

    assign alloc_gnt    = w_gnt;
    assign free_count   = w_free_count;
    assign init_done    = r_init_done;
    assign overflow_err = r_ovf;

endmodule
